board_renderer: RTL and testbench
=================================

# board_renderer

Pipelined, parametrised successor to the combinational board video generator. It renders a BOARD_ROWS×BOARD_COLS game board, a same-size preview area to its right, and a blinking cursor cell. Each cell holds a per-cell state written by the game controller. The block sits between the VGA timing controller (which supplies x/y, sync and pixel-enable) and the DAC pins, with a fixed 2-tick pixel latency and sync signals delayed to match.

## Interface
- BOARD_ROWS, 5, rows of main board and of preview area
- BOARD_COLS, 5, columns of main board; preview spans columns BOARD_COLS..2·BOARD_COLS-1
- CELL_SIZE, 58, cell pitch minus FRAME; pitch P = CELL_SIZE+FRAME
- FRAME, 2, border width in pixels
- BLINK_FRAMES, 30, frames per cursor blink half-period (≥1)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel tick; the pipeline advances only when high
- x, y  in  10 each  current pixel coordinate; x increments by 1 per pix_en and wraps to 0 at line start
- visible_in, hsync_in, vsync_in  in  1 each  timing signals for pixel (x,y)
- cur_row, cur_col  in  3 each  cursor cell (cur_row = i, cur_col = j)
- wr_en  in  1  cell-state write strobe (clk domain, independent of pix_en)
- wr_row, wr_col  in  3 each  write target
- wr_state  in  2  new cell state
- r, g, b  out  8 each  registered colour
- visible_out, hsync_out, vsync_out  out  1 each  inputs delayed by 2 pix_en ticks

## Operation
- Stage 1 (on pix_en), division-free position tracking:
  - x==0: col_off←0, col_idx←0; otherwise col_off←col_off+1, wrapping P-1→0 with col_idx+1.
  - col_idx saturates at 2·BOARD_COLS.
  - On pix_en with x==0: y==0 clears row_off/row_idx; otherwise row_off/row_idx advance identically, with row_idx saturating at BOARD_ROWS.
  - x, y, timing signals and cursor are registered alongside.
- Inside test: in_cell = FRAME ≤ col_off < CELL_SIZE and FRAME ≤ row_off < CELL_SIZE. This gives inclusive-exclusive bounds and a 56-pixel square at defaults.
  - main = in_cell, col_idx<BOARD_COLS, row_idx<BOARD_ROWS.
  - preview = in_cell, BOARD_COLS≤col_idx<2·BOARD_COLS, row_idx<BOARD_ROWS.
- Stage 2 (on pix_en), colour select in priority order:
  - visible=0 → 000000.
  - main and cell==cursor and blink_on=1 → FFFFFF.
  - main → state colour: 0 FF0000, 1 00FF00, 2 FFFF00, 3 808080.
  - preview → 0000FF.
  - else → 000000.
- Cell store: BOARD_ROWS·BOARD_COLS × 2-bit registers.
  - Synchronous write on wr_en when wr_row<BOARD_ROWS and wr_col<BOARD_COLS; out-of-range writes are ignored.
  - A read and a write to the same cell in the same clk return the old value; the new value is visible from the next clk.
- Cursor out of range (cur_row≥BOARD_ROWS or cur_col≥BOARD_COLS): no cell is highlighted.
- Blink: a frame start is pix_en with x==0 and y==0.
  - At each frame start, frame_cnt increments; at BLINK_FRAMES-1 it wraps to 0 and toggles blink_on.

## Timing
- Reset values: r/g/b=0, visible_out/hsync_out/vsync_out=0, all pipeline registers 0, all cells 0, frame_cnt=0, blink_on=1.
- Asynchronous reset takes effect immediately, including mid-frame. Tracking realigns at the next x==0 line start; correct rows resume from the next y==0.
- Latency: outputs for (x,y) appear after exactly 2 pix_en ticks. Syncs and visible are delayed by the same amount.
- pix_en low: all pipeline and blink registers hold; cell writes still occur.
- Blink period = 2·BLINK_FRAMES frames; the first toggle occurs at the BLINK_FRAMES-th frame start after reset.

## Test plan
- Reset, then scan one frame with pix_en every cycle, defaults.
  - x=2,y=2 → FF0000.
  - x=1,y=2 → 000000.
  - x=57 → FF0000; x=58 → 000000.
  - x=302,y=2 → 0000FF.
  - x=602 → 000000.
- Cursor (1,2), x=122,y=62, blink_on=1 → FFFFFF. After 30 frame starts → FF0000. After 60 → FFFFFF.
- Cell writes:
  - wr (0,0)=1 → x=10,y=10 gives 00FF00.
  - wr (4,4)=3 → x=250,y=250 gives 808080.
  - wr (5,0) ignored: all cells unchanged.
- Latency: toggle hsync_in/vsync_in/visible_in at known ticks → outputs follow exactly 2 pix_en later. visible_in=0 over a main cell → 000000. pix_en held low 10 cycles → outputs frozen.
- Reset asserted mid-line at x=200,y=100 → outputs 0 immediately, cells cleared, blink_on=1. After release, the next full frame renders correctly.
- Non-default BOARD_ROWS=8, BOARD_COLS=4, CELL_SIZE=28, FRAME=2 (P=30):
  - x=122,y=2 → 0000FF (col 4).
  - x=242 → 000000 (col 8).
  - y=242 → 000000 (row 8).

Source files
------------

// File: rtl/board_renderer.sv
// rtl/board_renderer.sv - two-stage pixel pipeline drawing board cells, preview area and blinking cursor
module board_renderer #(
    parameter int BOARD_ROWS   = 5,
    parameter int BOARD_COLS   = 5,
    parameter int CELL_SIZE    = 58,
    parameter int FRAME        = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       visible_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [2:0] cur_row,
    input  logic [2:0] cur_col,
    input  logic       wr_en,
    input  logic [2:0] wr_row,
    input  logic [2:0] wr_col,
    input  logic [1:0] wr_state,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       visible_out,
    output logic       hsync_out,
    output logic       vsync_out
);
    localparam int P  = CELL_SIZE + FRAME;
    localparam int OW = $clog2(P);
    localparam int CW = $clog2(2 * BOARD_COLS + 1);
    localparam int RW = $clog2(BOARD_ROWS + 1);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [OW-1:0] OFF_LAST   = OW'(P - 1);
    localparam logic [OW-1:0] OFF_LO     = OW'(FRAME);
    localparam logic [OW-1:0] OFF_HI     = OW'(CELL_SIZE);
    localparam logic [CW-1:0] COL_SAT    = CW'(2 * BOARD_COLS);
    localparam logic [CW-1:0] COL_MAIN   = CW'(BOARD_COLS);
    localparam logic [RW-1:0] ROW_SAT    = RW'(BOARD_ROWS);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [OW-1:0] col_off, row_off;
    logic [CW-1:0] col_idx;
    logic [RW-1:0] row_idx;
    logic          vis_s1, hs_s1, vs_s1;
    logic [2:0]    cur_row_s1, cur_col_s1;
    logic [1:0]    cells [BOARD_ROWS][BOARD_COLS];
    logic [FW-1:0] frame_cnt;
    logic          blink_on;

    logic          frame_start;
    logic          in_cell, main_cell, preview_cell, cursor_hit;
    logic [1:0]    cell_val;
    logic [23:0]   colour;

    assign frame_start = pix_en && (x == '0) && (y == '0);

    // Offsets count pixels within the current cell pitch so no divider is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_off    <= '0;
            col_idx    <= '0;
            row_off    <= '0;
            row_idx    <= '0;
            vis_s1     <= 1'b0;
            hs_s1      <= 1'b0;
            vs_s1      <= 1'b0;
            cur_row_s1 <= '0;
            cur_col_s1 <= '0;
        end else if (pix_en) begin
            if (x == '0) begin
                col_off <= '0;
                col_idx <= '0;
                if (y == '0) begin
                    row_off <= '0;
                    row_idx <= '0;
                end else if (row_off == OFF_LAST) begin
                    row_off <= '0;
                    if (row_idx != ROW_SAT) row_idx <= row_idx + 1'b1;
                end else begin
                    row_off <= row_off + 1'b1;
                end
            end else if (col_off == OFF_LAST) begin
                col_off <= '0;
                if (col_idx != COL_SAT) col_idx <= col_idx + 1'b1;
            end else begin
                col_off <= col_off + 1'b1;
            end
            vis_s1     <= visible_in;
            hs_s1      <= hsync_in;
            vs_s1      <= vsync_in;
            cur_row_s1 <= cur_row;
            cur_col_s1 <= cur_col;
        end
    end

    always_comb begin
        in_cell = (col_off >= OFF_LO) && (col_off < OFF_HI) &&
                  (row_off >= OFF_LO) && (row_off < OFF_HI);
        main_cell    = in_cell && (row_idx < ROW_SAT) && (col_idx < COL_MAIN);
        preview_cell = in_cell && (row_idx < ROW_SAT) && (col_idx >= COL_MAIN) && (col_idx < COL_SAT);
        // An out-of-range cursor can never equal an in-range main cell index.
        cursor_hit = (32'(cur_row_s1) == 32'(row_idx)) && (32'(cur_col_s1) == 32'(col_idx));
        cell_val = 2'd0;
        for (int rr = 0; rr < BOARD_ROWS; rr++) begin
            for (int cc = 0; cc < BOARD_COLS; cc++) begin
                if (row_idx == RW'(rr) && col_idx == CW'(cc)) cell_val = cells[rr][cc];
            end
        end
        colour = 24'h000000;
        if (!vis_s1) begin
            colour = 24'h000000;
        end else if (main_cell && cursor_hit && blink_on) begin
            colour = 24'hFFFFFF;
        end else if (main_cell) begin
            case (cell_val)
                2'd0:    colour = 24'hFF0000;
                2'd1:    colour = 24'h00FF00;
                2'd2:    colour = 24'hFFFF00;
                default: colour = 24'h808080;
            endcase
        end else if (preview_cell) begin
            colour = 24'h0000FF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {r, g, b}   <= '0;
            visible_out <= 1'b0;
            hsync_out   <= 1'b0;
            vsync_out   <= 1'b0;
        end else if (pix_en) begin
            {r, g, b}   <= colour;
            visible_out <= vis_s1;
            hsync_out   <= hs_s1;
            vsync_out   <= vs_s1;
        end
    end

    // Cell writes run on every clk; readers see the new value one clk later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int rr = 0; rr < BOARD_ROWS; rr++)
                for (int cc = 0; cc < BOARD_COLS; cc++)
                    cells[rr][cc] <= 2'd0;
        end else if (wr_en) begin
            for (int rr = 0; rr < BOARD_ROWS; rr++)
                for (int cc = 0; cc < BOARD_COLS; cc++)
                    if (wr_row == 3'(rr) && wr_col == 3'(cc)) cells[rr][cc] <= wr_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_start) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_board_renderer.sv
// tb/tb_board_renderer.sv - random scan frames against a division-based pixel model, two parameter sets
module tb_board_renderer;
    localparam int Y_END = 305;

    logic       clk = 1'b0;
    logic       rst, pix_en, visible_in, hsync_in, vsync_in, wr_en;
    logic [9:0] x, y;
    logic [2:0] cur_row, cur_col, wr_row, wr_col;
    logic [1:0] wr_state;
    logic [7:0] r0, g0, b0, r1, g1, b1;
    logic       vo0, ho0, so0, vo1, ho1, so1;

    always #5 clk = ~clk;

    board_renderer dut0 (
        .clk(clk), .rst(rst), .pix_en(pix_en), .x(x), .y(y),
        .visible_in(visible_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .cur_row(cur_row), .cur_col(cur_col), .wr_en(wr_en), .wr_row(wr_row),
        .wr_col(wr_col), .wr_state(wr_state), .r(r0), .g(g0), .b(b0),
        .visible_out(vo0), .hsync_out(ho0), .vsync_out(so0)
    );

    board_renderer #(
        .BOARD_ROWS(8), .BOARD_COLS(4), .CELL_SIZE(28), .FRAME(2), .BLINK_FRAMES(3)
    ) dut1 (
        .clk(clk), .rst(rst), .pix_en(pix_en), .x(x), .y(y),
        .visible_in(visible_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .cur_row(cur_row), .cur_col(cur_col), .wr_en(wr_en), .wr_row(wr_row),
        .wr_col(wr_col), .wr_state(wr_state), .r(r1), .g(g1), .b(b1),
        .visible_out(vo1), .hsync_out(ho1), .vsync_out(so1)
    );

    int NR[2] = '{5, 8};
    int NC[2] = '{5, 4};
    int CS[2] = '{58, 28};
    int FR[2] = '{2, 2};
    int BF[2] = '{30, 3};

    typedef struct {
        int x, y;
        bit vis, hs, vs;
        int cr, cc;
        bit ok;
    } pix_t;

    typedef struct {
        logic [23:0] rgb;
        logic [2:0]  tim;
        bit          ok;
        int          x, y;
    } exp_t;

    int   cells [2][8][8];
    bit   blink [2];
    int   fcnt [2];
    bit   track_ok;
    bit   rand_wr;
    pix_t m1;
    exp_t m2 [2];
    logic [23:0] spot [int];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] colour(int i, int px, int py, bit vis, int cr, int cc, bit bl);
        int  p, col, row, co, ro;
        bit  inc;
        p   = CS[i] + FR[i];
        col = px / p;
        co  = px % p;
        row = py / p;
        ro  = py % p;
        inc = co >= FR[i] && co < CS[i] && ro >= FR[i] && ro < CS[i];
        if (!vis || !inc || row >= NR[i]) return 24'h000000;
        if (col < NC[i]) begin
            if (bl && cr == row && cc == col) return 24'hFFFFFF;
            case (cells[i][row][col])
                0:       return 24'hFF0000;
                1:       return 24'h00FF00;
                2:       return 24'hFFFF00;
                default: return 24'h808080;
            endcase
        end
        if (col < 2 * NC[i]) return 24'h0000FF;
        return 24'h000000;
    endfunction

    function automatic int key(int i, int px, int py);
        return i * 1048576 + px * 1024 + py;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < 8; a++)
                for (int c = 0; c < 8; c++)
                    cells[i][a][c] = 0;
            blink[i] = 1'b1;
            fcnt[i]  = 0;
            m2[i]    = '{rgb: 24'h0, tim: 3'b0, ok: 1'b1, x: 1023, y: 1023};
        end
        track_ok = 1'b0;
        m1 = '{x: 0, y: 0, vis: 1'b0, hs: 1'b0, vs: 1'b0, cr: 0, cc: 0, ok: 1'b0};
    endtask

    // wmode: 1 = write the given cell, 2 = random write when rand_wr is set
    task automatic cycle(input bit pe, input int px, input int py, input bit vis, input bit hs,
                         input bit vs, input int wmode, input int wr_r, input int wr_c, input int wr_s);
        bit do_wr;
        int wr_rr, wr_cc, wr_ss;
        logic [23:0] obs0, obs1;
        do_wr = (wmode == 1);
        wr_rr = wr_r;
        wr_cc = wr_c;
        wr_ss = wr_s;
        if (wmode == 2 && rand_wr && $urandom_range(0, 15) == 0) begin
            do_wr = 1'b1;
            wr_rr = int'($urandom_range(0, 7));
            wr_cc = int'($urandom_range(0, 7));
            wr_ss = int'($urandom_range(0, 3));
        end
        pix_en = pe; x = 10'(px); y = 10'(py);
        visible_in = vis; hsync_in = hs; vsync_in = vs;
        wr_en = do_wr; wr_row = 3'(wr_rr); wr_col = 3'(wr_cc); wr_state = 2'(wr_ss);
        @(posedge clk);
        if (pe) begin
            for (int i = 0; i < 2; i++)
                m2[i] = '{rgb: colour(i, m1.x, m1.y, m1.vis, m1.cr, m1.cc, blink[i]),
                          tim: {m1.vis, m1.hs, m1.vs}, ok: m1.ok, x: m1.x, y: m1.y};
            if (px == 0 && py == 0) begin
                track_ok = 1'b1;
                for (int i = 0; i < 2; i++) begin
                    fcnt[i]++;
                    if (fcnt[i] == BF[i]) begin
                        fcnt[i]  = 0;
                        blink[i] = !blink[i];
                    end
                end
            end
            m1 = '{x: px, y: py, vis: vis, hs: hs, vs: vs, cr: int'(cur_row), cc: int'(cur_col), ok: track_ok};
        end
        if (do_wr)
            for (int i = 0; i < 2; i++)
                if (wr_rr < NR[i] && wr_cc < NC[i]) cells[i][wr_rr][wr_cc] = wr_ss;
        #1;
        wr_en = 1'b0;
        obs0 = {r0, g0, b0};
        obs1 = {r1, g1, b1};
        check("tim0", 32'({vo0, ho0, so0}), 32'(m2[0].tim));
        check("tim1", 32'({vo1, ho1, so1}), 32'(m2[1].tim));
        if (m2[0].ok) begin
            check("rgb0", 32'(obs0), 32'(m2[0].rgb));
            spot[key(0, m2[0].x, m2[0].y)] = obs0;
        end
        if (m2[1].ok) begin
            check("rgb1", 32'(obs1), 32'(m2[1].rgb));
            spot[key(1, m2[1].x, m2[1].y)] = obs1;
        end
    endtask

    task automatic pix(input bit pe, input int px, input int py, input bit vis, input bit hs, input bit vs);
        cycle(pe, px, py, vis, hs, vs, 2, 0, 0, 0);
    endtask

    task automatic write_cell(input int wr_r, input int wr_c, input int wr_s);
        cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1, wr_r, wr_c, wr_s);
    endtask

    // Lines la/lb/lc are scanned xlen pixels wide; every other line is a single x==0 tick.
    task automatic frame(input int la, input int lb, input int lc, input int xlen, input bit rnd);
        for (int yy = 0; yy <= Y_END; yy++) begin
            int n;
            n = (yy == la || yy == lb || yy == lc) ? xlen : 1;
            for (int xx = 0; xx < n; xx++) begin
                if ($urandom_range(0, 7) == 0)
                    pix(1'b0, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                pix(1'b1, xx, yy, rnd ? ($urandom_range(0, 7) != 0) : 1'b1,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b0; x = '0; y = '0;
        visible_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        cur_row = 3'd1; cur_col = 3'd2;
        wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_state = '0;
        rand_wr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rgb0", 32'({r0, g0, b0}), 32'h0);
        check("reset_tim0", 32'({vo0, ho0, so0}), 32'h0);
        check("reset_rgb1", 32'({r1, g1, b1}), 32'h0);
        check("reset_tim1", 32'({vo1, ho1, so1}), 32'h0);
        rst = 1'b0;

        for (int k = 1; k <= 60; k++) begin
            spot.delete();
            if (k == 1) frame(2, 62, 242, 640, 1'b0);
            else        frame(-1, 62, -1, 131, 1'b0);
            if (k == 1) begin
                check("in_cell_x2", 32'(spot[key(0, 2, 2)]), 32'hFF0000);
                check("frame_x1", 32'(spot[key(0, 1, 2)]), 32'h000000);
                check("edge_x57", 32'(spot[key(0, 57, 2)]), 32'hFF0000);
                check("edge_x58", 32'(spot[key(0, 58, 2)]), 32'h000000);
                check("preview", 32'(spot[key(0, 302, 2)]), 32'h0000FF);
                check("beyond_x602", 32'(spot[key(0, 602, 2)]), 32'h000000);
                check("row4", 32'(spot[key(0, 2, 242)]), 32'hFF0000);
                check("alt_preview", 32'(spot[key(1, 122, 2)]), 32'h0000FF);
                check("alt_col8", 32'(spot[key(1, 242, 2)]), 32'h000000);
                check("alt_row8", 32'(spot[key(1, 2, 242)]), 32'h000000);
            end
            if (k == 1 || k == 60) check("cursor_on", 32'(spot[key(0, 122, 62)]), 32'hFFFFFF);
            if (k == 30) check("cursor_off", 32'(spot[key(0, 122, 62)]), 32'hFF0000);
        end

        write_cell(0, 0, 1);
        write_cell(4, 4, 3);
        write_cell(5, 0, 2);
        spot.delete();
        frame(10, 62, 250, 640, 1'b0);
        check("wr_00", 32'(spot[key(0, 10, 10)]), 32'h00FF00);
        check("wr_44", 32'(spot[key(0, 250, 250)]), 32'h808080);
        check("wr_oob_40", 32'(spot[key(0, 10, 250)]), 32'hFF0000);
        check("wr_oob_04", 32'(spot[key(0, 250, 10)]), 32'hFF0000);
        check("cursor_wr", 32'(spot[key(0, 122, 62)]), 32'hFFFFFF);

        for (int yy = 0; yy < 100; yy++) pix(1'b1, 0, yy, 1'b1, 1'b0, 1'b0);
        for (int xx = 0; xx <= 200; xx++) pix(1'b1, xx, 100, 1'b1, 1'b1, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rgb0", 32'({r0, g0, b0}), 32'h0);
        check("async_tim0", 32'({vo0, ho0, so0}), 32'h0);
        check("async_rgb1", 32'({r1, g1, b1}), 32'h0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int xx = 201; xx < 640; xx++) pix(1'b1, xx, 100, 1'b1, 1'b0, 1'b1);
        for (int yy = 101; yy <= Y_END; yy++) pix(1'b1, 0, yy, 1'b1, 1'b0, 1'b0);
        spot.delete();
        frame(10, 62, 250, 640, 1'b0);
        check("rst_cleared", 32'(spot[key(0, 10, 10)]), 32'hFF0000);
        check("rst_cleared44", 32'(spot[key(0, 250, 250)]), 32'hFF0000);
        check("rst_blink", 32'(spot[key(0, 122, 62)]), 32'hFFFFFF);

        rand_wr = 1'b1;
        for (int f = 0; f < 8; f++) begin
            cur_row = 3'($urandom_range(0, 7));
            cur_col = 3'($urandom_range(0, 7));
            frame(int'($urandom_range(0, Y_END)), int'($urandom_range(0, Y_END)),
                  int'($urandom_range(0, Y_END)), int'($urandom_range(300, 650)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
